// File: rtl/fp16_norm_pack.sv
// Normalise-and-pack stage: turns {sign, biased exp, 12-bit magnitude} into an IEEE half word,
// one left shift per clock. Optional macro ROUND_NEAREST_EN rounds the single right shift to nearest even.
module fp16_norm_pack #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   sr,
  input  logic [EXP_W-1:0]       e5,
  input  logic [MAN_W+1:0]       mf,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   zero,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [EXP_W-1:0] EXP_MAX   = '1;
  localparam logic [EXP_W-1:0] EXP_ONE   = EXP_W'(1);
  localparam logic [EXP_W:0]   EXP_MAX_X = {1'b0, EXP_MAX};

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t           state_q, state_d;
  logic             sign_q, sign_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [MAN_W+1:0] man_q, man_d;
  logic [W-1:0]     result_d;
  logic             zero_d, overflow_d, underflow_d;

  logic             round_up;
  logic [MAN_W+1:0] rnd_man;
  logic [EXP_W:0]   rnd_exp;
  logic [MAN_W-1:0] rnd_frac;

  // Carry path: one right shift, optionally rounded; a round-up to 2.0 bumps the exponent again.
`ifdef ROUND_NEAREST_EN
  assign round_up = man_q[0] & man_q[1];
`else
  assign round_up = 1'b0;
`endif
  assign rnd_man  = {1'b0, man_q[MAN_W+1:1]} + (MAN_W+2)'(round_up);
  assign rnd_exp  = {1'b0, exp_q} + (EXP_W+1)'(1) + (EXP_W+1)'(rnd_man[MAN_W+1]);
  assign rnd_frac = rnd_man[MAN_W+1] ? '0 : rnd_man[MAN_W-1:0];

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);

  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    man_d       = man_q;
    result_d    = result;
    zero_d      = zero;
    overflow_d  = overflow;
    underflow_d = underflow;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          sign_d  = sr;
          exp_d   = (e5 == '0) ? EXP_ONE : e5;
          man_d   = mf;
          state_d = NORM;
        end
      end
      NORM: begin
        state_d     = DONE;
        zero_d      = 1'b0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (man_q == '0) begin
          result_d = {sign_q, {(W-1){1'b0}}};
          zero_d   = 1'b1;
        end else if (exp_q == EXP_MAX) begin
          result_d   = {sign_q, EXP_MAX, {MAN_W{1'b0}}};
          overflow_d = 1'b1;
        end else if (man_q[MAN_W+1]) begin
          if (rnd_exp >= EXP_MAX_X) begin
            result_d   = {sign_q, EXP_MAX, {MAN_W{1'b0}}};
            overflow_d = 1'b1;
          end else begin
            result_d = {sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
          end
        end else if (man_q[MAN_W]) begin
          result_d = {sign_q, exp_q, man_q[MAN_W-1:0]};
        end else if (exp_q == EXP_ONE) begin
          // Hidden bit still clear at the minimum exponent: pack as subnormal.
          result_d    = {sign_q, {EXP_W{1'b0}}, man_q[MAN_W-1:0]};
          underflow_d = 1'b1;
        end else begin
          man_d   = man_q << 1;
          exp_d   = exp_q - EXP_ONE;
          state_d = NORM;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: all datapath registers are cleared too, so an aborted operation leaves nothing behind.
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      man_q     <= '0;
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      man_q     <= man_d;
      result    <= result_d;
      zero      <= zero_d;
      overflow  <= overflow_d;
      underflow <= underflow_d;
    end
  end

endmodule

// File: tb/tb_fp16_norm_pack.sv
// Randomised self-checking bench for fp16_norm_pack; the reference model works on integer values.
// Build with ROUND_NEAREST_EN defined or not, matching the RTL build.
module tb_fp16_norm_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic        sr;
  logic [4:0]  e5;
  logic [11:0] mf;
  logic        out_valid, out_ready;
  logic [15:0] result;
  logic        zero, overflow, underflow;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int res;
    int flags;   // {zero, overflow, underflow}
    int shifts;
  } ref_t;

  fp16_norm_pack dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sr(sr), .e5(e5), .mf(mf), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Value-level model: count the leading-zero shifts needed, capped by the exponent floor.
  function automatic ref_t model(input int s, input int e5v, input int mfv);
    ref_t r;
    int e, q, p, sft;
    r.res = s << 15; r.flags = 0; r.shifts = 0;
    e = (e5v == 0) ? 1 : e5v;
    if (mfv == 0) begin
      r.flags = 4;
    end else if (e == 31) begin
      r.res += 31 << 10; r.flags = 2;
    end else if (mfv >= 2048) begin
      q = mfv / 2;
`ifdef ROUND_NEAREST_EN
      if ((mfv % 2 == 1) && (q % 2 == 1)) q++;
`endif
      e++;
      if (q == 2048) begin q = 1024; e++; end
      if (e >= 31) begin r.res += 31 << 10; r.flags = 2; end
      else r.res += (e << 10) + (q % 1024);
    end else begin
      p = 10;
      while (mfv < (1 << p)) p--;
      sft = 10 - p;
      if (sft <= e - 1) begin
        r.res += ((e - sft) << 10) + ((mfv << sft) % 1024);
      end else begin
        sft = e - 1;
        r.res += (mfv << sft) % 1024;
        r.flags = 1;
      end
      r.shifts = sft;
    end
    return r;
  endfunction

  // Drives one operation from a negedge, checks latency, outputs, hold behaviour and handshake.
  task automatic run_op(input logic s, input logic [4:0] e, input logic [11:0] m, input int hold,
                        input logic [15:0] xr, input logic [2:0] xf, input int xlat);
    int edges;
    check("ready_before", 32'(in_ready), 32'd1);
    sr = s; e5 = e; mf = m; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; sr = 1'($urandom); e5 = 5'($urandom); mf = 12'($urandom);
    check("ready_busy", 32'(in_ready), 32'd0);
    edges = 0;
    while (!out_valid && edges < 20) begin
      @(posedge clk); @(negedge clk);
      edges++;
    end
    check("latency", 32'(edges), 32'(xlat));
    check("result", 32'(result), 32'(xr));
    check("flags", 32'({zero, overflow, underflow}), 32'(xf));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; sr = 1'($urandom); e5 = 5'($urandom); mf = 12'($urandom);
      @(posedge clk); @(negedge clk);
      check("hold_result", 32'(result), 32'(xr));
      check("hold_valid", 32'({out_valid, in_ready}), 32'b10);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check("release", 32'({out_valid, in_ready}), 32'b01);
  endtask

  initial begin
    ref_t r;
    logic [4:0]  re;
    logic [11:0] rm;
    logic        rs;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sr = 1'b0; e5 = '0; mf = '0;
    repeat (2) @(negedge clk);
    check("rst_out", 32'({out_valid, in_ready, zero, overflow, underflow}), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    run_op(1'b0, 5'd15, 12'h400, 0, 16'h3C00, 3'b000, 1);
`ifdef ROUND_NEAREST_EN
    run_op(1'b0, 5'd15, 12'h803, 0, 16'h4002, 3'b000, 1);
`else
    run_op(1'b0, 5'd15, 12'h803, 0, 16'h4001, 3'b000, 1);
`endif
    run_op(1'b0, 5'd15, 12'h080, 5, 16'h3000, 3'b000, 4);
    run_op(1'b1, 5'd9,  12'h000, 0, 16'h8000, 3'b100, 1);
    run_op(1'b0, 5'd30, 12'h800, 0, 16'h7C00, 3'b010, 1);
    run_op(1'b0, 5'd2,  12'h040, 0, 16'h0080, 3'b001, 2);
    run_op(1'b1, 5'd31, 12'h7FF, 0, 16'hFC00, 3'b010, 1);
    run_op(1'b0, 5'd0,  12'h001, 1, 16'h0001, 3'b001, 1);
`ifdef ROUND_NEAREST_EN
    run_op(1'b0, 5'd29, 12'hFFF, 0, 16'h7C00, 3'b010, 1);
`else
    run_op(1'b0, 5'd29, 12'hFFF, 0, 16'h7BFF, 3'b000, 1);
`endif

    // Reset in the middle of normalisation discards the operation.
    sr = 1'b0; e5 = 5'd15; mf = 12'h080; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_mid_valid", 32'(out_valid), 32'd0);
    end
    check("rst_mid_result", 32'(result), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst", 32'({out_valid, in_ready}), 32'b01);
    end
    run_op(1'b0, 5'd15, 12'h400, 0, 16'h3C00, 3'b000, 1);

    // Random operations with a spread of leading-one positions.
    for (int k = 0; k < 300; k++) begin
      rs = 1'($urandom);
      re = 5'($urandom);
      rm = 12'($urandom & ((32'd1 << $urandom_range(0, 12)) - 1));
      r  = model(int'(rs), int'(re), int'(rm));
      run_op(rs, re, rm, $urandom_range(0, 2), 16'(r.res), 3'(r.flags), r.shifts + 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
